// File: rtl/vga_fetch_pkg.sv
// Shared types and constants for the frame-fetch scheduler: FSM state encoding,
// default raster size and the pixel-counter width helper.
package vga_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DRAIN   = 2'd2,
        WAIT_VS = 2'd3
    } state_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    // Width of a counter that spans 0 .. n-1; never narrower than one bit.
    function automatic int pix_cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pixel_fetch_sched_if.sv
// ROM read port and pixel-FIFO write port of the fetch scheduler, bundled as one
// interface; master is the scheduler, slave is the ROM/FIFO side.
interface pixel_fetch_sched_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 24
);
    // Handshake: rom_en and fifo_wr_en are single-cycle strobes with no ready.
    // The ROM returns rom_data exactly ROM_LAT cycles after each rom_en, and the
    // FIFO accepts every fifo_wr_en. Back-pressure exists only through
    // fifo_afull, which is sampled before a read is issued; fifo_full is status.
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              fifo_afull;
    logic              fifo_full;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_din;

    modport master (
        output rom_en,
        output rom_addr,
        input  rom_data,
        input  fifo_afull,
        input  fifo_full,
        output fifo_wr_en,
        output fifo_din
    );

    modport slave (
        input  rom_en,
        input  rom_addr,
        output rom_data,
        output fifo_afull,
        output fifo_full,
        input  fifo_wr_en,
        input  fifo_din
    );

endinterface

// File: rtl/fetch_vsync_sync.sv
// Brings the active-low pixel-domain vsync into clk with two flops, then emits a
// one-cycle vs_start pulse on its falling edge.
module fetch_vsync_sync (
    input  logic clk,
    input  logic rst,
    input  logic vsync_px,
    output logic vs_start
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Flops reset high (vsync inactive) so leaving reset never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= vsync_px;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign vs_start = prev_q & ~sync_q;

endmodule

// File: rtl/pixel_fetch_sched.sv
// Raster-order image-ROM fetcher feeding the dual-clock pixel FIFO, re-armed by
// vsync. Define FETCH_TESTPAT_EN to replace ROM data with the issued address.
module pixel_fetch_sched
    import vga_fetch_pkg::*;
#(
    parameter int                H_ACTIVE  = H_ACTIVE_DEF,
    parameter int                V_ACTIVE  = V_ACTIVE_DEF,
    parameter int                ADDR_W    = 24,
    parameter int                DATA_W    = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ROM_LAT   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                vsync_px,
    pixel_fetch_sched_if.master bus,
    output logic                start_display,
    output logic                frame_done,
    output logic                busy,
    output state_t              state
);

    localparam int              NPIX     = H_ACTIVE * V_ACTIVE;
    localparam int              PIX_W    = pix_cnt_width(NPIX);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NPIX - 1);

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [PIX_W-1:0]    pix_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic                issue;
    logic                load;
    logic                issue_q;
    logic                last_q;
    logic [ROM_LAT-1:0]  vld_q;
    logic [ROM_LAT-1:0]  lst_q;
    logic [ROM_LAT:0]    chain;
    logic                in_flight;
    logic                start_q;
    logic                vs_start;
    logic                wr;

    fetch_vsync_sync u_vsync (
        .clk      (clk),
        .rst      (rst),
        .vsync_px (vsync_px),
        .vs_start (vs_start)
    );

    // Reads that will still produce a write after this cycle; the stage at the
    // tail is being written now and no longer holds the FSM back.
    assign chain     = {vld_q, issue_q};
    assign in_flight = |chain[ROM_LAT-1:0];

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = FETCH;
                    load    = 1'b1;
                end
            end
            FETCH: begin
                if (!enable) begin
                    if (!in_flight) state_d = IDLE;
                end else if (!bus.fifo_afull) begin
                    issue = 1'b1;
                    if (pix_q == LAST_PIX) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!in_flight) state_d = enable ? WAIT_VS : IDLE;
            end
            WAIT_VS: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (vs_start) begin
                    state_d = FETCH;
                    load    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= BASE_ADDR;
            pix_q      <= '0;
            rom_addr_q <= BASE_ADDR;
            issue_q    <= 1'b0;
            last_q     <= 1'b0;
            vld_q      <= '0;
            lst_q      <= '0;
            start_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            issue_q <= issue;
            last_q  <= issue && (pix_q == LAST_PIX);
            if (load) begin
                addr_q <= BASE_ADDR;
                pix_q  <= '0;
            end else if (issue) begin
                addr_q     <= addr_q + ADDR_W'(1);
                pix_q      <= pix_q + PIX_W'(1);
                rom_addr_q <= addr_q;
            end
            vld_q[0] <= issue_q;
            lst_q[0] <= last_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                lst_q[i] <= lst_q[i-1];
            end
            if (state_d == IDLE) begin
                start_q <= 1'b0;
            end else if (state_q != IDLE && bus.fifo_full) begin
                start_q <= 1'b1;
            end
        end
    end

    assign wr             = vld_q[ROM_LAT-1];
    assign bus.rom_addr   = rom_addr_q;
    assign bus.fifo_wr_en = wr;
    assign frame_done     = wr & lst_q[ROM_LAT-1];
    assign start_display  = start_q;
    assign busy           = (state_q != IDLE);
    assign state          = state_q;

`ifdef FETCH_TESTPAT_EN
    logic [ADDR_W-1:0] pat_q [ROM_LAT];

    // Address pipeline aligned with the valid chain, standing in for the ROM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROM_LAT; i++) pat_q[i] <= '0;
        end else begin
            pat_q[0] <= rom_addr_q;
            for (int i = 1; i < ROM_LAT; i++) pat_q[i] <= pat_q[i-1];
        end
    end

    assign bus.rom_en   = 1'b0;
    assign bus.fifo_din = wr ? DATA_W'(pat_q[ROM_LAT-1]) : '0;
`else
    assign bus.rom_en   = issue_q;
    assign bus.fifo_din = wr ? bus.rom_data : '0;
`endif

endmodule

// File: tb/tb_pixel_fetch_sched.sv
// Directed, table-driven bench for pixel_fetch_sched on a 4x2 raster, ROM_LAT=2,
// with hand-written sequences for vsync restart, enable abort and mid-frame reset.
`timescale 1ns/1ps
module tb_pixel_fetch_sched;
    import vga_fetch_pkg::*;

    localparam int              H    = 4;
    localparam int              V    = 2;
    localparam int              AW   = 24;
    localparam int              DW   = 24;
    localparam int              LAT  = 2;
    localparam logic [AW-1:0]   BASE = 24'h000100;
`ifdef FETCH_TESTPAT_EN
    localparam logic EN_ON = 1'b0;
`else
    localparam logic EN_ON = 1'b1;
`endif

    logic   clk = 1'b0;
    logic   rst;
    logic   enable;
    logic   vsync_px;
    logic   start_display;
    logic   frame_done;
    logic   busy;
    state_t state;

    pixel_fetch_sched_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    pixel_fetch_sched #(
        .H_ACTIVE  (H),
        .V_ACTIVE  (V),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .BASE_ADDR (BASE),
        .ROM_LAT   (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .vsync_px      (vsync_px),
        .bus           (bus),
        .start_display (start_display),
        .frame_done    (frame_done),
        .busy          (busy),
        .state         (state)
    );

    always #5 clk = ~clk;

    // ---- ROM model: registered two-stage read, data valid 2 cycles after rom_en
    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return a ^ 24'hA5C300;
    endfunction

    function automatic logic [DW-1:0] exp_din(input logic [AW-1:0] a);
`ifdef FETCH_TESTPAT_EN
        return a;
`else
        return rom_f(a);
`endif
    endfunction

    logic [DW-1:0] rom_p1;
    always @(posedge clk) begin
        rom_p1       <= bus.rom_en ? rom_f(bus.rom_addr) : 24'hBAD000;
        bus.rom_data <= rom_p1;
    end

    // ---- scoreboard and counters
    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---- vector table
    typedef struct {
        logic          en;
        logic          afull;
        logic          full;
        logic          x_rom_en;
        logic [AW-1:0] x_addr;
        logic          x_wr;
        logic [DW-1:0] x_din;
        logic          x_fd;
        logic          x_sd;
        state_t        x_st;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic en, input logic af, input logic fl, input logic ren,
                       input logic [AW-1:0] addr, input logic wr, input logic [AW-1:0] src,
                       input logic fd, input logic sd, input state_t st);
        vec_t v;
        v.en = en; v.afull = af; v.full = fl;
        v.x_rom_en = ren; v.x_addr = addr; v.x_wr = wr;
        v.x_din = wr ? exp_din(src) : '0;
        v.x_fd = fd; v.x_sd = sd; v.x_st = st;
        tbl.push_back(v);
    endtask

    task automatic wait_fetch(input string name, output int k);
        k = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (state == FETCH) begin
                k = i;
                break;
            end
        end
        chk({name, " latency ok"}, 32'(k >= 3 && k <= 4), 32'd1);
    endtask

    int k;
    int n_en;
    int n_wr;
    int n_fd;
    logic [AW-1:0] exp_addr;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; vsync_px = 1'b1;
        bus.fifo_afull = 1'b0; bus.fifo_full = 1'b0;
        repeat (3) step();
        chk("rst rom_en",   32'(bus.rom_en), 0);
        chk("rst rom_addr", 32'(bus.rom_addr), 32'(BASE));
        chk("rst wr_en",    32'(bus.fifo_wr_en), 0);
        chk("rst din",      32'(bus.fifo_din), 0);
        chk("rst start",    32'(start_display), 0);
        chk("rst done",     32'(frame_done), 0);
        chk("rst busy",     32'(busy), 0);
        chk("rst state",    32'(state), 32'(IDLE));
        rst = 1'b0;
        step();
        chk("idle hold", 32'(state), 32'(IDLE));

        // frame 1: no throttling
        add(1,0,0, 0,24'h100, 0,0,      0,0, FETCH);
        add(1,0,0, 1,24'h100, 0,0,      0,0, FETCH);
        add(1,0,0, 1,24'h101, 0,0,      0,0, FETCH);
        add(1,0,0, 1,24'h102, 1,24'h100,0,0, FETCH);
        add(1,0,0, 1,24'h103, 1,24'h101,0,0, FETCH);
        add(1,0,0, 1,24'h104, 1,24'h102,0,0, FETCH);
        add(1,0,0, 1,24'h105, 1,24'h103,0,0, FETCH);
        add(1,0,0, 1,24'h106, 1,24'h104,0,0, FETCH);
        add(1,0,0, 1,24'h107, 1,24'h105,0,0, DRAIN);
        add(1,0,0, 0,24'h107, 1,24'h106,0,0, DRAIN);
        add(1,0,0, 0,24'h107, 1,24'h107,1,0, DRAIN);
        add(1,0,0, 0,24'h107, 0,0,      0,0, WAIT_VS);
        // enable low in WAIT_VS returns to IDLE
        add(0,0,0, 0,24'h107, 0,0,      0,0, IDLE);
        // frame 2: afull on FETCH cycles 3..5, fifo_full after the 5th write
        add(1,0,0, 0,24'h107, 0,0,      0,0, FETCH);
        add(1,0,0, 1,24'h100, 0,0,      0,0, FETCH);
        add(1,1,0, 0,24'h100, 0,0,      0,0, FETCH);
        add(1,1,0, 0,24'h100, 1,24'h100,0,0, FETCH);
        add(1,1,0, 0,24'h100, 0,0,      0,0, FETCH);
        add(1,0,0, 1,24'h101, 0,0,      0,0, FETCH);
        add(1,0,0, 1,24'h102, 0,0,      0,0, FETCH);
        add(1,0,0, 1,24'h103, 1,24'h101,0,0, FETCH);
        add(1,0,0, 1,24'h104, 1,24'h102,0,0, FETCH);
        add(1,0,0, 1,24'h105, 1,24'h103,0,0, FETCH);
        add(1,0,0, 1,24'h106, 1,24'h104,0,0, FETCH);
        add(1,0,1, 1,24'h107, 1,24'h105,0,1, DRAIN);
        add(1,0,0, 0,24'h107, 1,24'h106,0,1, DRAIN);
        add(1,0,0, 0,24'h107, 1,24'h107,1,1, DRAIN);
        add(1,0,0, 0,24'h107, 0,0,      0,1, WAIT_VS);

        for (int i = 0; i < tbl.size(); i++) begin
            enable = tbl[i].en; bus.fifo_afull = tbl[i].afull; bus.fifo_full = tbl[i].full;
            step();
            chk($sformatf("v%0d rom_en", i),   32'(bus.rom_en),     32'(tbl[i].x_rom_en & EN_ON));
            chk($sformatf("v%0d rom_addr", i), 32'(bus.rom_addr),   32'(tbl[i].x_addr));
            chk($sformatf("v%0d wr_en", i),    32'(bus.fifo_wr_en), 32'(tbl[i].x_wr));
            chk($sformatf("v%0d din", i),      32'(bus.fifo_din),   32'(tbl[i].x_din));
            chk($sformatf("v%0d done", i),     32'(frame_done),     32'(tbl[i].x_fd));
            chk($sformatf("v%0d start", i),    32'(start_display),  32'(tbl[i].x_sd));
            chk($sformatf("v%0d busy", i),     32'(busy),           32'(tbl[i].x_st != IDLE));
            chk($sformatf("v%0d state", i),    32'(state),          32'(tbl[i].x_st));
        end
        bus.fifo_full = 1'b0;

        // vsync falling edge restarts; a second edge during FETCH is ignored
        vsync_px = 1'b0;
        wait_fetch("vs1", k);
        exp_addr = BASE; n_en = 0; n_fd = 0;
        exp_q.delete();
        for (int i = 0; i < H*V; i++) exp_q.push_back(exp_din(BASE + AW'(i)));
        for (int m = 1; m <= 20; m++) begin
            step();
            if (m == 1) vsync_px = 1'b1;
            if (m == 4) vsync_px = 1'b0;
            if (bus.rom_en) begin
                chk($sformatf("vs1 addr %0d", n_en), 32'(bus.rom_addr), 32'(exp_addr));
                exp_addr = exp_addr + AW'(1);
                n_en++;
            end
            if (bus.fifo_wr_en) begin
                if (exp_q.size() == 0) chk("vs1 extra write", 32'(bus.fifo_din), 32'hFFFFFFFF);
                else chk("vs1 din", 32'(bus.fifo_din), 32'(exp_q.pop_front()));
            end
            if (frame_done) n_fd++;
            chk("vs1 start held", 32'(start_display), 1);
            if (state == WAIT_VS) break;
        end
        chk("vs1 issues",    32'(n_en), 32'(8 * int'(EN_ON)));
        chk("vs1 writes left", 32'(exp_q.size()), 0);
        chk("vs1 done count", 32'(n_fd), 1);
        chk("vs1 end state", 32'(state), 32'(WAIT_VS));

        // enable dropped with two reads in flight
        vsync_px = 1'b1;
        repeat (3) step();
        chk("ab wait", 32'(state), 32'(WAIT_VS));
        vsync_px = 1'b0;
        wait_fetch("ab", k);
        step();
        step();
        chk("ab rom_en", 32'(bus.rom_en), 32'(EN_ON));
        chk("ab addr",   32'(bus.rom_addr), 32'h101);
        chk("ab start",  32'(start_display), 1);
        enable = 1'b0;
        exp_q.delete();
        exp_q.push_back(exp_din(24'h100));
        exp_q.push_back(exp_din(24'h101));
        n_en = 0; n_wr = 0;
        for (int m = 0; m < 6; m++) begin
            step();
            if (bus.rom_en) n_en++;
            if (bus.fifo_wr_en) begin
                n_wr++;
                if (exp_q.size() == 0) chk("ab extra write", 32'(bus.fifo_din), 32'hFFFFFFFF);
                else chk("ab din", 32'(bus.fifo_din), 32'(exp_q.pop_front()));
            end
        end
        chk("ab issues", 32'(n_en), 0);
        chk("ab writes", 32'(n_wr), 2);
        chk("ab state",  32'(state), 32'(IDLE));
        chk("ab busy",   32'(busy), 0);
        chk("ab start",  32'(start_display), 0);

        // reset asserted mid-FETCH with a write on the port
        enable = 1'b1;
        repeat (4) step();
        chk("mr wr before", 32'(bus.fifo_wr_en), 1);
        rst = 1'b1;
        #1;
        chk("mr rom_en",   32'(bus.rom_en), 0);
        chk("mr rom_addr", 32'(bus.rom_addr), 32'(BASE));
        chk("mr wr_en",    32'(bus.fifo_wr_en), 0);
        chk("mr din",      32'(bus.fifo_din), 0);
        chk("mr start",    32'(start_display), 0);
        chk("mr done",     32'(frame_done), 0);
        chk("mr busy",     32'(busy), 0);
        chk("mr state",    32'(state), 32'(IDLE));
        #2;
        enable = 1'b0;
        rst = 1'b0;
        n_wr = 0;
        for (int m = 0; m < 4; m++) begin
            step();
            if (bus.fifo_wr_en) n_wr++;
        end
        chk("mr no stale writes", 32'(n_wr), 0);
        chk("mr idle",            32'(state), 32'(IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
